// File: rtl/matrix_c_reader_if.sv
// matrix_c_reader_if: RAM read port and element stream between the C reader and its neighbours
//   rd_en/rd_addr/rd_data      : read port of the C result RAM (data one cycle after rd_en)
//   out_valid/out_ready        : element stream handshake
//   out_data/out_row/out_col   : signed element and its row/col tag
//   out_last                   : marks element 63
//   master = reader side, slave = RAM plus consumer side
interface matrix_c_reader_if #(parameter int DW = 19, parameter int AW = 6);
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic signed [DW-1:0] rd_data;
  logic out_valid;
  logic out_ready;
  logic signed [DW-1:0] out_data;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic out_last;
  modport master(output rd_en, rd_addr, out_valid, out_data, out_row, out_col, out_last,
                 input rd_data, out_ready);
  modport slave(input rd_en, rd_addr, out_valid, out_data, out_row, out_col, out_last,
                output rd_data, out_ready);
endinterface

// File: rtl/matrix_c_reader.sv
// matrix_c_reader: streams the 64 signed C results out of the result RAM in column-major order
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : one-cycle pulse, honoured only when idle
//   busy_o     : high from start accept until the last handshake
//   done_o     : one-cycle pulse after the last handshake
//   sum_o      : running sum of streamed elements (only with CREADER_SUM_EN defined)
//   bus        : RAM read port plus element stream (matrix_c_reader_if.master)
module matrix_c_reader #(
  parameter int DW = 19,
  parameter int AW = 6,
  parameter int NWORDS = 64,
  parameter int NROWS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
`ifdef CREADER_SUM_EN
  output logic signed [DW+5:0] sum_o,
`endif
  matrix_c_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, tag_q, head_tag;
  logic inflight_q, done_q, wr_q, rd_q;
  logic [1:0] count_q, occ;
  logic [AW+DW-1:0] mem_q [2];
  logic pop, push, last, final_addr;
  assign push = inflight_q;
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  always_comb begin
    head_tag = mem_q[rd_q][AW+DW-1:DW];
    bus.out_valid = count_q != 2'd0;
    bus.out_data = mem_q[rd_q][DW-1:0];
    bus.out_row = 3'(head_tag % NROWS);
    bus.out_col = 3'(head_tag / NROWS);
    last = head_tag == AW'(NWORDS - 1);
    bus.out_last = bus.out_valid & last;
    pop = bus.out_valid & bus.out_ready;
    // occupancy counts the slot freed by this cycle's pop, so steady state keeps one read per cycle
    occ = count_q + {1'b0, inflight_q} - {1'b0, pop};
    bus.rd_en = state_q == READ && occ < 2'd2;
    bus.rd_addr = addr_q;
    final_addr = addr_q == AW'(NWORDS - 1);
    state_d = state_q;
    addr_d = addr_q;
    if (state_q == IDLE && start_i) begin
      state_d = READ;
      addr_d = '0;
    end else if (bus.rd_en) begin
      state_d = final_addr ? DRAIN : READ;
      addr_d = final_addr ? addr_q : addr_q + 1'b1;
    end else if (state_q == DRAIN && pop && last) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      tag_q <= '0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      inflight_q <= bus.rd_en;
      if (bus.rd_en) tag_q <= addr_q;
      if (push) begin
        mem_q[wr_q] <= {tag_q, bus.rd_data};
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      done_q <= pop & bus.out_last;
    end
  end
`ifdef CREADER_SUM_EN
  logic signed [DW+5:0] sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else if (state_q == IDLE && start_i) sum_q <= '0;
    else if (pop) sum_q <= sum_q + {{6{bus.out_data[DW-1]}}, bus.out_data};
  end
  assign sum_o = sum_q;
`endif
endmodule
